// File: rtl/filter_test_sequencer_pkg.sv
// Shared widths and state encoding for the filter test sequencer.
package filter_test_sequencer_pkg;

  localparam int unsigned SIZE_DELAY       = 8;
  localparam int unsigned SIZE_FILTER_DATA = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FIRE,
    OBSERVE,
    GAP,
    REPORT,
    FINISH
  } seq_state_t;

endpackage

// File: rtl/filter_test_sequencer_peak_tracker.sv
// Running unsigned maximum with synchronous clear; peak_c includes the current sample.
module filter_test_sequencer_peak_tracker #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] peak_c
);

  logic [WIDTH-1:0] peak_q;

  // Next maximum: clear wins, strictly larger samples replace the held value
  always_comb begin
    peak_c = peak_q;
    if (clear) begin
      peak_c = '0;
    end else if (enable && (data > peak_q)) begin
      peak_c = data;
    end
  end

  // Held maximum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_c;
    end
  end

endmodule

// File: rtl/filter_test_sequencer.sv
// Delay-sweep controller for the exponential test-signal generator: fires N
// pulses per delay step and reports the peak of the selected filter output.
module filter_test_sequencer
  import filter_test_sequencer_pkg::*;
#(
  parameter int unsigned WINDOW_LEN = 64,
  parameter int unsigned GAP_LEN    = 16,
  parameter int unsigned SIZE_STEP  = 8,
  parameter int unsigned SIZE_PULSE = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        overlay_en,
  input  logic [SIZE_DELAY-1:0]       delay_start,
  input  logic [SIZE_DELAY-1:0]       delay_step,
  input  logic [SIZE_STEP-1:0]        num_steps,
  input  logic [SIZE_PULSE-1:0]       pulses_per_step,
  input  logic [SIZE_FILTER_DATA-1:0] filter_data,
  output logic                        test_rate,
  output logic                        test_overlay,
  output logic [SIZE_DELAY-1:0]       test_delay,
  output logic [SIZE_FILTER_DATA-1:0] peak_data,
  output logic [SIZE_STEP-1:0]        peak_step,
  output logic                        peak_valid,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned CNT_W = $clog2((WINDOW_LEN > GAP_LEN) ? WINDOW_LEN : GAP_LEN);
  localparam int unsigned PW    = SIZE_PULSE + 1;
  localparam int unsigned SW    = SIZE_STEP + 1;
  localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(WINDOW_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_LEN - 1);

  seq_state_t                  state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [SIZE_STEP-1:0]        step_q, step_d;
  logic [SIZE_PULSE-1:0]       pulse_q, pulse_d;
  logic [SIZE_DELAY-1:0]       delay_q, delay_d;
  logic                        overlay_q, overlay_d;
  logic                        rate_q, rate_d;
  logic                        valid_q, valid_d;
  logic                        done_q, done_d;
  logic                        busy_q, busy_d;
  logic [SIZE_FILTER_DATA-1:0] peak_data_q, peak_data_d;
  logic [SIZE_STEP-1:0]        peak_step_q, peak_step_d;
  logic [SIZE_DELAY-1:0]       cfg_dstart_q, cfg_dstart_d;
  logic [SIZE_DELAY-1:0]       cfg_dstep_q, cfg_dstep_d;
  logic [SIZE_STEP-1:0]        cfg_nsteps_q, cfg_nsteps_d;
  logic [SIZE_PULSE-1:0]       cfg_pulses_q, cfg_pulses_d;
  logic                        cfg_overlay_q, cfg_overlay_d;

  logic                        trk_clear, trk_enable;
  logic [SIZE_FILTER_DATA-1:0] trk_peak_c;
  logic [SIZE_PULSE-1:0]       pulse_target;
  logic                        pulse_more, step_last;

  filter_test_sequencer_peak_tracker #(
    .WIDTH (SIZE_FILTER_DATA)
  ) u_peak (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (trk_clear),
    .enable (trk_enable),
    .data   (filter_data),
    .peak_c (trk_peak_c)
  );

  // A programmed pulse count of zero still fires one pulse
  always_comb begin
    pulse_target = (cfg_pulses_q == '0) ? SIZE_PULSE'(1) : cfg_pulses_q;
    pulse_more   = (PW'(pulse_q) + PW'(1)) < PW'(pulse_target);
    step_last    = (SW'(step_q) + SW'(1)) == SW'(cfg_nsteps_q);
  end

  // Next-state, counters and registered-output decode; abort overrides everything
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    step_d        = step_q;
    pulse_d       = pulse_q;
    delay_d       = delay_q;
    overlay_d     = overlay_q;
    rate_d        = 1'b0;
    valid_d       = 1'b0;
    done_d        = 1'b0;
    busy_d        = 1'b0;
    peak_data_d   = peak_data_q;
    peak_step_d   = peak_step_q;
    cfg_dstart_d  = cfg_dstart_q;
    cfg_dstep_d   = cfg_dstep_q;
    cfg_nsteps_d  = cfg_nsteps_q;
    cfg_pulses_d  = cfg_pulses_q;
    cfg_overlay_d = cfg_overlay_q;
    trk_clear     = 1'b0;
    trk_enable    = 1'b0;

    if (abort) begin
      if (state_q != IDLE) begin
        state_d   = IDLE;
        overlay_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cfg_dstart_d  = delay_start;
            cfg_dstep_d   = delay_step;
            cfg_nsteps_d  = num_steps;
            cfg_pulses_d  = pulses_per_step;
            cfg_overlay_d = overlay_en;
            state_d       = LOAD;
          end
        end
        LOAD: begin
          step_d    = '0;
          pulse_d   = '0;
          delay_d   = cfg_dstart_q;
          trk_clear = 1'b1;
          state_d   = (cfg_nsteps_q == '0) ? FINISH : FIRE;
        end
        FIRE: begin
          cnt_d   = WIN_LOAD;
          state_d = OBSERVE;
        end
        OBSERVE: begin
          trk_enable = 1'b1;
          if (cnt_q == '0) begin
            if (pulse_more) begin
              pulse_d = pulse_q + SIZE_PULSE'(1);
              cnt_d   = GAP_LOAD;
              state_d = GAP;
            end else begin
              state_d = REPORT;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_d = FIRE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        REPORT: begin
          trk_clear = 1'b1;
          pulse_d   = '0;
          if (step_last) begin
            state_d = FINISH;
          end else begin
            step_d  = step_q + SIZE_STEP'(1);
            delay_d = delay_q + cfg_dstep_q;
            cnt_d   = GAP_LOAD;
            state_d = GAP;
          end
        end
        FINISH: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    rate_d  = (state_d == FIRE);
    valid_d = (state_d == REPORT);
    done_d  = (state_d == FINISH);
    busy_d  = (state_d != IDLE);
    if (state_d == FIRE) begin
      overlay_d = cfg_overlay_q & pulse_d[0];
    end
    if (state_d == REPORT) begin
      peak_data_d = trk_peak_c;
      peak_step_d = step_q;
    end
  end

  // State, counters, configuration and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      step_q        <= '0;
      pulse_q       <= '0;
      delay_q       <= '0;
      overlay_q     <= 1'b0;
      rate_q        <= 1'b0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      peak_data_q   <= '0;
      peak_step_q   <= '0;
      cfg_dstart_q  <= '0;
      cfg_dstep_q   <= '0;
      cfg_nsteps_q  <= '0;
      cfg_pulses_q  <= '0;
      cfg_overlay_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      step_q        <= step_d;
      pulse_q       <= pulse_d;
      delay_q       <= delay_d;
      overlay_q     <= overlay_d;
      rate_q        <= rate_d;
      valid_q       <= valid_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      peak_data_q   <= peak_data_d;
      peak_step_q   <= peak_step_d;
      cfg_dstart_q  <= cfg_dstart_d;
      cfg_dstep_q   <= cfg_dstep_d;
      cfg_nsteps_q  <= cfg_nsteps_d;
      cfg_pulses_q  <= cfg_pulses_d;
      cfg_overlay_q <= cfg_overlay_d;
    end
  end

  // A same-cycle abort withdraws the report/finish strobes
  assign peak_valid   = valid_q & ~abort;
  assign done         = done_q & ~abort;
  assign test_rate    = rate_q;
  assign test_overlay = overlay_q;
  assign test_delay   = delay_q;
  assign peak_data    = peak_data_q;
  assign peak_step    = peak_step_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_filter_test_sequencer.sv
// Scoreboard bench for filter_test_sequencer: expected fires, reports and
// completions are queued by the stimulus and consumed by a negedge monitor.
module tb_filter_test_sequencer;
  import filter_test_sequencer_pkg::*;

  localparam int unsigned WL = 8;
  localparam int unsigned GL = 4;
  localparam int unsigned SS = 8;
  localparam int unsigned SP = 8;
  localparam int unsigned DW = SIZE_DELAY;
  localparam int unsigned FW = SIZE_FILTER_DATA;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          overlay_en = 1'b0;
  logic [DW-1:0] delay_start = '0;
  logic [DW-1:0] delay_step = '0;
  logic [SS-1:0] num_steps = '0;
  logic [SP-1:0] pulses_per_step = '0;
  logic [FW-1:0] filter_data = '1;
  logic          test_rate, test_overlay, peak_valid, busy, done;
  logic [DW-1:0] test_delay;
  logic [FW-1:0] peak_data;
  logic [SS-1:0] peak_step;

  filter_test_sequencer #(
    .WINDOW_LEN (WL),
    .GAP_LEN    (GL),
    .SIZE_STEP  (SS),
    .SIZE_PULSE (SP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .overlay_en      (overlay_en),
    .delay_start     (delay_start),
    .delay_step      (delay_step),
    .num_steps       (num_steps),
    .pulses_per_step (pulses_per_step),
    .filter_data     (filter_data),
    .test_rate       (test_rate),
    .test_overlay    (test_overlay),
    .test_delay      (test_delay),
    .peak_data       (peak_data),
    .peak_step       (peak_step),
    .peak_valid      (peak_valid),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] delay;
    logic          ov;
    int            spacing;
  } fire_t;

  typedef struct {
    logic [SS-1:0] step;
    logic [FW-1:0] data;
  } rep_t;

  typedef struct {
    logic [FW-1:0] peak;
    int            pos;
  } pulse_t;

  fire_t  fire_q[$];
  rep_t   rep_q[$];
  pulse_t pk_q[$];
  int     exp_done = 0;
  int     n_tests = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     last_fire = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every strobe the DUT presents is matched against the queues
  always @(negedge clk) begin : monitor
    fire_t fe;
    rep_t  re;
    if (reset) begin
      if (test_rate) begin
        if (fire_q.size() == 0) begin
          check("unexpected test_rate", 32'(test_rate), 0);
        end else begin
          fe = fire_q.pop_front();
          check("fire test_delay", 32'(test_delay), 32'(fe.delay));
          check("fire test_overlay", 32'(test_overlay), 32'(fe.ov));
          if (fe.spacing != 0) check("fire spacing", 32'(cyc - last_fire), 32'(fe.spacing));
        end
        last_fire = cyc;
      end
      if (peak_valid) begin
        if (rep_q.size() == 0) begin
          check("unexpected peak_valid", 32'(peak_valid), 0);
        end else begin
          re = rep_q.pop_front();
          check("report peak_step", 32'(peak_step), 32'(re.step));
          check("report peak_data", 32'(peak_data), 32'(re.data));
        end
      end
      if (done) begin
        if (exp_done == 0) check("unexpected done", 32'(done), 0);
        else exp_done--;
      end
    end
  end

  // Filter model: after each fire, drive the observation window; 0xFFFF outside it
  initial begin : driver
    pulse_t p;
    forever begin
      @(negedge clk);
      if (reset && test_rate) begin
        if (pk_q.size() != 0) p = pk_q.pop_front();
        else begin
          p.peak = '0;
          p.pos  = 0;
        end
        for (int i = 0; i < int'(WL); i++) begin
          @(posedge clk);
          #1 filter_data = (i == p.pos) ? p.peak : (p.peak >> 1);
        end
        @(posedge clk);
        #1 filter_data = '1;
      end
    end
  end

  task automatic set_cfg(input logic [DW-1:0] ds, input logic [DW-1:0] dst,
                         input logic [SS-1:0] ns, input logic [SP-1:0] pp, input logic ov);
    delay_start     = ds;
    delay_step      = dst;
    num_steps       = ns;
    pulses_per_step = pp;
    overlay_en      = ov;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic exp_fire(input logic [DW-1:0] d, input logic ov, input int sp);
    fire_q.push_back('{delay: d, ov: ov, spacing: sp});
  endtask

  task automatic exp_rep(input logic [SS-1:0] s, input logic [FW-1:0] d);
    rep_q.push_back('{step: s, data: d});
  endtask

  task automatic add_pulse(input logic [FW-1:0] pk, input int pos);
    pk_q.push_back('{peak: pk, pos: pos});
  endtask

  task automatic wait_fire(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (test_rate) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit idle = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    check(name, 32'(idle), 1);
    repeat (3) @(negedge clk);
    check({name, " fires left"}, 32'(fire_q.size()), 0);
    check({name, " reports left"}, 32'(rep_q.size()), 0);
    check({name, " dones left"}, 32'(exp_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs", {test_rate, test_overlay, test_delay, peak_data, peak_step,
                            peak_valid, busy, done}, 0);
    reset = 1'b1;

    // Basic sweep: three steps of one pulse, delay 10/15/20
    set_cfg(8'd10, 8'd5, 8'd3, 8'd1, 1'b0);
    exp_fire(8'd10, 1'b0, 0);
    exp_fire(8'd15, 1'b0, 14);
    exp_fire(8'd20, 1'b0, 14);
    add_pulse(16'h0123, 3);
    add_pulse(16'h0123, 7);
    add_pulse(16'h0123, 0);
    exp_rep(8'd0, 16'h0123);
    exp_rep(8'd1, 16'h0123);
    exp_rep(8'd2, 16'h0123);
    exp_done = 1;
    pulse_start();
    wait_idle(200, "basic sweep");

    // Asynchronous reset in the middle of an observation window
    set_cfg(8'd77, 8'd1, 8'd1, 8'd1, 1'b0);
    exp_fire(8'd77, 1'b0, 0);
    add_pulse(16'h0200, 2);
    pulse_start();
    wait_fire(50, "reset test fire");
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async reset outputs", {test_rate, test_overlay, test_delay, peak_data, peak_step,
                                  peak_valid, busy, done}, 0);
    pk_q.delete();
    rep_q.delete();
    exp_done = 0;
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (30) @(negedge clk);
    check("after reset busy", 32'(busy), 0);
    check("after reset test_delay", 32'(test_delay), 0);

    // Four pulses with overlay; peaks 100, 300, 200, 300
    set_cfg(8'h33, 8'd1, 8'd1, 8'd4, 1'b1);
    exp_fire(8'h33, 1'b0, 0);
    exp_fire(8'h33, 1'b1, 13);
    exp_fire(8'h33, 1'b0, 13);
    exp_fire(8'h33, 1'b1, 13);
    add_pulse(16'd100, 0);
    add_pulse(16'd300, 7);
    add_pulse(16'd200, 3);
    add_pulse(16'd300, 3);
    exp_rep(8'd0, 16'd300);
    exp_done = 1;
    pulse_start();
    wait_idle(200, "overlay sweep");
    check("overlay held after sweep", 32'(test_overlay), 1);

    // Delay wrap-around, with a distinct peak per step
    set_cfg(8'd250, 8'd5, 8'd3, 8'd1, 1'b0);
    exp_fire(8'd250, 1'b0, 0);
    exp_fire(8'd255, 1'b0, 14);
    exp_fire(8'd4, 1'b0, 14);
    add_pulse(16'd500, 5);
    add_pulse(16'd40, 1);
    add_pulse(16'd7, 6);
    exp_rep(8'd0, 16'd500);
    exp_rep(8'd1, 16'd40);
    exp_rep(8'd2, 16'd7);
    exp_done = 1;
    pulse_start();
    wait_idle(200, "wrap sweep");

    // Empty sweep: done two cycles after start, nothing fired
    set_cfg(8'd0, 8'd0, 8'd0, 8'd1, 1'b0);
    exp_done = 1;
    @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    check("empty done at start", 32'(done), 0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("empty busy in LOAD", 32'(busy), 1);
    check("empty done in LOAD", 32'(done), 0);
    @(negedge clk);
    check("empty done in FINISH", 32'(done), 1);
    wait_idle(20, "empty sweep");

    // Abort on the report cycle of step 1
    set_cfg(8'd20, 8'd3, 8'd3, 8'd1, 1'b0);
    exp_fire(8'd20, 1'b0, 0);
    exp_fire(8'd23, 1'b0, 14);
    add_pulse(16'h0321, 4);
    add_pulse(16'h0111, 1);
    exp_rep(8'd0, 16'h0321);
    pulse_start();
    wait_fire(50, "abort test fire 0");
    wait_fire(50, "abort test fire 1");
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    check("abort peak_valid", 32'(peak_valid), 0);
    check("abort busy same cycle", 32'(busy), 1);
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort busy next", 32'(busy), 0);
    check("abort test_delay held", 32'(test_delay), 32'(8'd23));
    check("abort test_overlay", 32'(test_overlay), 0);
    wait_idle(60, "abort sweep");

    // Start while busy is ignored; live config changes do not leak in
    set_cfg(8'd60, 8'd2, 8'd2, 8'd1, 1'b0);
    exp_fire(8'd60, 1'b0, 0);
    exp_fire(8'd62, 1'b0, 14);
    add_pulse(16'h0400, 1);
    add_pulse(16'h0055, 6);
    exp_rep(8'd0, 16'h0400);
    exp_rep(8'd1, 16'h0055);
    exp_done = 1;
    pulse_start();
    repeat (4) @(posedge clk);
    set_cfg(8'd0, 8'd9, 8'd5, 8'd3, 1'b1);
    pulse_start();
    wait_idle(200, "start while busy");

    // Start together with abort in IDLE stays idle
    set_cfg(8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
    @(posedge clk);
    #1 start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("start+abort busy", 32'(busy), 0);
    wait_idle(30, "start+abort");

    // Zero pulses per step behaves as one
    set_cfg(8'd7, 8'd1, 8'd2, 8'd0, 1'b0);
    exp_fire(8'd7, 1'b0, 0);
    exp_fire(8'd8, 1'b0, 14);
    add_pulse(16'h0abc, 2);
    add_pulse(16'h0001, 5);
    exp_rep(8'd0, 16'h0abc);
    exp_rep(8'd1, 16'h0001);
    exp_done = 1;
    pulse_start();
    wait_idle(200, "zero pulses");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
